// File: rtl/data_memory_access_unit.sv
// MEM-stage load/store unit: req/ack data-bus transaction with byte-lane steering,
// load extension, alignment checking and bus timeout; stalls the pipeline per access.
module data_memory_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Mem_Size,
    input  logic        Load_Unsigned,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] Write_Data,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Wdata,
    output logic [3:0]  Mem_Be,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Rdata,
    output logic [31:0] Read_Data,
    output logic        Stall,
    output logic        Access_Error,
    output logic        Bus_Error
);

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           size_q;
    logic [1:0]           off_q;
    logic                 uns_q;

    logic        req_any;
    logic        aligned;
    logic        valid;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] lane;
    logic [31:0] load_ext;

    always_comb begin
        req_any = MemRead | MemWrite;
        case (Mem_Size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~ALU_Result[0];
            2'b10:   aligned = (ALU_Result[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        valid = (MemRead ^ MemWrite) & aligned;
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = Write_Data;
        if (MemWrite) begin
            case (Mem_Size)
                2'b00: begin
                    be_n    = 4'b0001 << ALU_Result[1:0];
                    wdata_n = {4{Write_Data[7:0]}};
                end
                2'b01: begin
                    be_n    = ALU_Result[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{Write_Data[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = Write_Data;
                end
            endcase
        end
    end

    // Shifting the addressed lane down to bit 0 serves both byte and half extraction.
    always_comb begin
        lane = Mem_Rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = Mem_Rdata;
        endcase
    end

    always_comb begin
        case (state)
            IDLE:    Stall = valid;
            ACCESS:  Stall = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            size_q       <= '0;
            off_q        <= '0;
            uns_q        <= 1'b0;
            Mem_Req      <= 1'b0;
            Mem_We       <= 1'b0;
            Mem_Addr     <= '0;
            Mem_Wdata    <= '0;
            Mem_Be       <= '0;
            Read_Data    <= '0;
            Access_Error <= 1'b0;
            Bus_Error    <= 1'b0;
        end else begin
            Access_Error <= 1'b0;
            Bus_Error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        Mem_Addr  <= {ALU_Result[31:2], 2'b00};
                        Mem_We    <= MemWrite;
                        Mem_Be    <= be_n;
                        Mem_Wdata <= wdata_n;
                        size_q    <= Mem_Size;
                        off_q     <= ALU_Result[1:0];
                        uns_q     <= Load_Unsigned;
                        cnt       <= '0;
                        Mem_Req   <= 1'b1;
                        state     <= ACCESS;
                    end else if (req_any) begin
                        Access_Error <= 1'b1;
                        state        <= COMPLETE;
                    end
                end
                ACCESS: begin
                    if (Mem_Ack) begin
                        if (!Mem_We) Read_Data <= load_ext;
                        Mem_Req <= 1'b0;
                        state   <= COMPLETE;
                    end else if (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        Bus_Error <= 1'b1;
                        if (!Mem_We) Read_Data <= '0;
                        Mem_Req <= 1'b0;
                        state   <= COMPLETE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMPLETE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Self-checking bench for data_memory_access_unit: directed plan scenarios plus
// randomized transactions checked against a transaction-level reference model.
module tb_data_memory_access_unit;

    localparam int TMO = 4;

    logic        Clk;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Mem_Size;
    logic        Load_Unsigned;
    logic [31:0] ALU_Result;
    logic [31:0] Write_Data;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic [3:0]  Mem_Be;
    logic        Mem_Ack;
    logic [31:0] Mem_Rdata;
    logic [31:0] Read_Data;
    logic        Stall;
    logic        Access_Error;
    logic        Bus_Error;

    int passed = 0;
    int checks = 0;

    data_memory_access_unit #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Mem_Size(Mem_Size), .Load_Unsigned(Load_Unsigned), .ALU_Result(ALU_Result),
        .Write_Data(Write_Data), .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_Wdata(Mem_Wdata), .Mem_Be(Mem_Be), .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata),
        .Read_Data(Read_Data), .Stall(Stall), .Access_Error(Access_Error), .Bus_Error(Bus_Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Observations collected by do_access for one transaction.
    int          o_stall, o_req, o_aerr, o_berr;
    logic        o_we, o_hung, o_req_after, o_stall_complete;
    logic [31:0] o_addr, o_wdata, o_rd_complete, o_rd_after;
    logic [3:0]  o_be;

    // Reference model: lane arithmetic from the byte address and access size.
    function automatic logic [31:0] m_load(logic [31:0] rdata, logic [1:0] size, logic uns, logic [31:0] addr);
        int bits = 8 * (1 << size);
        longint unsigned v = (longint'(rdata) >> (8 * (addr % 4))) & ((64'd1 << bits) - 1);
        if (!uns && (((v >> (bits - 1)) & 1) == 1)) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [31:0] wd, logic [1:0] size);
        int nb = 1 << size;
        longint unsigned unit = longint'(wd) & ((64'd1 << (8 * nb)) - 1);
        longint unsigned r = 0;
        for (int i = 0; i < 4 / nb; i++) r = r | (unit << (8 * nb * i));
        return r[31:0];
    endfunction

    function automatic logic [3:0] m_be(logic rd, logic [1:0] size, logic [31:0] addr);
        int nb = 1 << size;
        int v = ((1 << nb) - 1) << (addr % 4);
        if (rd) return 4'hF;
        return v[3:0];
    endfunction

    function automatic bit m_valid(logic rd, logic wr, logic [1:0] size, logic [31:0] addr);
        return (rd != wr) && (size != 2'd3) && ((addr % (1 << size)) == 0);
    endfunction

    // Drives one instruction until it completes; ack arrives in ACCESS cycle index ack_after (<0: never).
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                             input int ack_after);
        int acc = 0;
        o_stall = 0; o_req = 0; o_aerr = 0; o_berr = 0; o_hung = 1'b1;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0; o_stall_complete = 1'b0;
        @(negedge Clk);
        MemRead = rd; MemWrite = wr; Mem_Size = size; Load_Unsigned = uns;
        ALU_Result = addr; Write_Data = wd; Mem_Rdata = rdata; Mem_Ack = 1'b0;
        #1;
        o_stall += int'(Stall); o_aerr += int'(Access_Error); o_berr += int'(Bus_Error);
        for (int k = 0; k < 64; k++) begin
            @(negedge Clk); #1;
            o_stall += int'(Stall); o_aerr += int'(Access_Error); o_berr += int'(Bus_Error);
            if (Mem_Req) begin
                o_req++;
                o_addr = Mem_Addr; o_wdata = Mem_Wdata; o_be = Mem_Be; o_we = Mem_We;
                Mem_Ack = (ack_after >= 0) && (acc == ack_after);
                acc++;
            end else begin
                o_rd_complete = Read_Data;
                o_stall_complete = Stall;
                Mem_Ack = 1'b1;
                Mem_Rdata = $urandom;
                o_hung = 1'b0;
                break;
            end
        end
        @(negedge Clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        o_stall += int'(Stall); o_aerr += int'(Access_Error); o_berr += int'(Bus_Error);
        o_rd_after = Read_Data;
        o_req_after = Mem_Req;
    endtask

    task automatic test_reset();
        MemRead = 0; MemWrite = 0; Mem_Size = 0; Load_Unsigned = 0; ALU_Result = 0;
        Write_Data = 0; Mem_Ack = 0; Mem_Rdata = 0; Reset = 1;
        repeat (3) @(negedge Clk);
        Reset = 0;
        #1;
        checks++; if (Mem_Req !== 1'b0) $display("FAIL reset_req: got %b want 0", Mem_Req); else passed++;
        checks++; if (Stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", Stall); else passed++;
        checks++; if (Read_Data !== 32'h0) $display("FAIL reset_rd: got %h want 0", Read_Data); else passed++;
        checks++; if ({Mem_We, Mem_Be, Mem_Addr, Mem_Wdata} !== '0) $display("FAIL reset_bus: got %b/%h/%h/%h want 0", Mem_We, Mem_Be, Mem_Addr, Mem_Wdata); else passed++;
        checks++; if ({Access_Error, Bus_Error} !== 2'b00) $display("FAIL reset_err: got %b want 00", {Access_Error, Bus_Error}); else passed++;
    endtask

    task automatic test_load_word();
        do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checks++; if (o_hung !== 1'b0) $display("FAIL lw_done: transaction never completed"); else passed++;
        checks++; if (o_stall !== 2) $display("FAIL lw_stall_cycles: got %0d want 2", o_stall); else passed++;
        checks++; if (o_req !== 1) $display("FAIL lw_req_cycles: got %0d want 1", o_req); else passed++;
        checks++; if (o_rd_complete !== 32'hDEADBEEF) $display("FAIL lw_rd: got %h want deadbeef", o_rd_complete); else passed++;
        checks++; if (o_be !== 4'hF || o_we !== 1'b0 || o_addr !== 32'h100) $display("FAIL lw_bus: got be %h we %b addr %h want f 0 100", o_be, o_we, o_addr); else passed++;
        checks++; if (o_stall_complete !== 1'b0) $display("FAIL lw_complete_stall: got %b want 0", o_stall_complete); else passed++;
    endtask

    task automatic test_byte_load_ext();
        do_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF0000, 0);
        checks++; if (o_rd_complete !== 32'hFFFFFF80) $display("FAIL lb_signed: got %h want ffffff80", o_rd_complete); else passed++;
        do_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF0000, 1);
        checks++; if (o_rd_complete !== 32'h00000080) $display("FAIL lb_unsigned: got %h want 00000080", o_rd_complete); else passed++;
        checks++; if (o_stall !== 3) $display("FAIL lb_late_ack_stall: got %0d want 3", o_stall); else passed++;
    endtask

    task automatic test_half_store();
        do_access(1, 0, 2'b01, 1, 32'h40, 32'h0, 32'h0000C3A5, 0);
        do_access(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0);
        checks++; if (o_addr !== 32'h200) $display("FAIL sh_addr: got %h want 200", o_addr); else passed++;
        checks++; if (o_be !== 4'b1100) $display("FAIL sh_be: got %b want 1100", o_be); else passed++;
        checks++; if (o_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); else passed++;
        checks++; if (o_we !== 1'b1) $display("FAIL sh_we: got %b want 1", o_we); else passed++;
        checks++; if (o_rd_after !== 32'h0000C3A5) $display("FAIL sh_rd_hold: got %h want 0000c3a5", o_rd_after); else passed++;
    endtask

    task automatic test_misaligned();
        do_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h12345678, 0);
        checks++; if (o_aerr !== 1) $display("FAIL mis_aerr: got %0d pulses want 1", o_aerr); else passed++;
        checks++; if (o_req !== 0) $display("FAIL mis_req: got %0d req cycles want 0", o_req); else passed++;
        checks++; if (o_stall !== 0) $display("FAIL mis_stall: got %0d stall cycles want 0", o_stall); else passed++;
        checks++; if (o_rd_after !== 32'h0000C3A5) $display("FAIL mis_rd_hold: got %h want 0000c3a5", o_rd_after); else passed++;
    endtask

    task automatic test_timeout();
        do_access(1, 0, 2'b10, 0, 32'h80, 32'h0, 32'h11111111, -1);
        checks++; if (o_req !== TMO) $display("FAIL tmo_access_cycles: got %0d want %0d", o_req, TMO); else passed++;
        checks++; if (o_berr !== 1) $display("FAIL tmo_berr: got %0d pulses want 1", o_berr); else passed++;
        checks++; if (o_rd_complete !== 32'h0) $display("FAIL tmo_rd: got %h want 0", o_rd_complete); else passed++;
        checks++; if (o_stall_complete !== 1'b0) $display("FAIL tmo_complete_stall: got %b want 0", o_stall_complete); else passed++;
        checks++; if (o_stall !== TMO + 1) $display("FAIL tmo_stall_cycles: got %0d want %0d", o_stall, TMO + 1); else passed++;
    endtask

    task automatic test_reset_abort();
        do_access(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h55AA55AA, 0);
        @(negedge Clk);
        MemRead = 1; MemWrite = 0; Mem_Size = 2'b10; ALU_Result = 32'h10; Mem_Ack = 0;
        @(negedge Clk); #1;
        checks++; if (Mem_Req !== 1'b1) $display("FAIL abort_in_access: got req %b want 1", Mem_Req); else passed++;
        @(negedge Clk);
        Reset = 1; MemRead = 0;
        @(negedge Clk);
        Reset = 0; Mem_Ack = 1; Mem_Rdata = 32'hFFFFFFFF;
        #1;
        checks++; if (Mem_Req !== 1'b0 || Stall !== 1'b0) $display("FAIL abort_req_stall: got %b%b want 00", Mem_Req, Stall); else passed++;
        checks++; if (Read_Data !== 32'h0) $display("FAIL abort_rd: got %h want 0", Read_Data); else passed++;
        @(negedge Clk);
        Mem_Ack = 0;
        #1;
        checks++; if (Read_Data !== 32'h0 || Mem_Req !== 1'b0) $display("FAIL abort_ack_ignored: got rd %h req %b want 0 0", Read_Data, Mem_Req); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] model_rd = 32'h0;
        for (int n = 0; n < 60; n++) begin
            int r = int'($urandom_range(0, 9));
            logic rd = (r <= 4) || (r == 9);
            logic wr = (r >= 5);
            logic [1:0] size = 2'($urandom_range(0, 3));
            logic uns = 1'($urandom_range(0, 1));
            logic [31:0] addr = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rdata = $urandom;
            int ack_after = int'($urandom_range(0, 5)) - 1;
            bit v = m_valid(rd, wr, size, addr);
            bit tmo = (ack_after < 0) || (ack_after >= TMO);
            int acc = tmo ? TMO : ack_after + 1;
            if (r == 3) addr[1:0] = 2'b00;
            v = m_valid(rd, wr, size, addr);
            if (v && rd) model_rd = tmo ? 32'h0 : m_load(rdata, size, uns, addr);
            do_access(rd, wr, size, uns, addr, wd, rdata, ack_after);
            checks++; if (o_hung !== 1'b0) $display("FAIL rnd_done[%0d]: never completed", n); else passed++;
            checks++; if (o_stall !== (v ? acc + 1 : 0)) $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, o_stall, v ? acc + 1 : 0); else passed++;
            checks++; if (o_req !== (v ? acc : 0)) $display("FAIL rnd_req[%0d]: got %0d want %0d", n, o_req, v ? acc : 0); else passed++;
            checks++; if (o_aerr !== int'(!v)) $display("FAIL rnd_aerr[%0d]: got %0d want %0d", n, o_aerr, int'(!v)); else passed++;
            checks++; if (o_berr !== int'(v && tmo)) $display("FAIL rnd_berr[%0d]: got %0d want %0d", n, o_berr, int'(v && tmo)); else passed++;
            checks++; if (o_rd_after !== model_rd) $display("FAIL rnd_rd[%0d]: got %h want %h", n, o_rd_after, model_rd); else passed++;
            checks++; if (o_req_after !== 1'b0) $display("FAIL rnd_req_after[%0d]: got %b want 0", n, o_req_after); else passed++;
            if (v) begin
                checks++; if (o_addr !== {addr[31:2], 2'b00}) $display("FAIL rnd_addr[%0d]: got %h want %h", n, o_addr, {addr[31:2], 2'b00}); else passed++;
                checks++; if (o_be !== m_be(rd, size, addr)) $display("FAIL rnd_be[%0d]: got %b want %b", n, o_be, m_be(rd, size, addr)); else passed++;
                checks++; if (o_we !== wr) $display("FAIL rnd_we[%0d]: got %b want %b", n, o_we, wr); else passed++;
                if (wr) begin
                    checks++; if (o_wdata !== m_wdata(wd, size)) $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o_wdata, m_wdata(wd, size)); else passed++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_byte_load_ext();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
